// File: rtl/mc_ctrl_ex_if.sv
// Control bundle between the multi-cycle controller and the shared-memory datapath.
// The controller uses the master side; the datapath uses the slave side.
interface mc_ctrl_ex_if #(
    parameter int ALU_OP_W = 3
);
    logic [31:0]         Inst_in;
    logic                zero;
    logic                overflow;
    logic                MIO_ready;

    logic                MemRead;
    logic                MemWrite;
    logic                CPU_MIO;
    logic                IorD;
    logic                IRWrite;
    logic                RegWrite;
    logic                ALUSrcA;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                Branch;
    logic [1:0]          RegDst;
    logic [1:0]          MemtoReg;
    logic [1:0]          ALUSrcB;
    logic [1:0]          PCSource;
    logic [ALU_OP_W-1:0] ALU_operation;
    logic                EPCWrite;
    logic                CauseWrite;
    logic [1:0]          cause;

    // Memory handshake: a transfer completes on the rising edge where the
    // controller holds MemRead/MemWrite with CPU_MIO=1 and MIO_ready=1.
    modport master (
        input  Inst_in, zero, overflow, MIO_ready,
        output MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA,
               PCWrite, PCWriteCond, Branch, RegDst, MemtoReg, ALUSrcB,
               PCSource, ALU_operation, EPCWrite, CauseWrite, cause
    );

    modport slave (
        output Inst_in, zero, overflow, MIO_ready,
        input  MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA,
               PCWrite, PCWriteCond, Branch, RegDst, MemtoReg, ALUSrcB,
               PCSource, ALU_operation, EPCWrite, CauseWrite, cause
    );
endinterface

// File: rtl/mc_ctrl_ex.sv
// Multi-cycle MIPS control FSM with optional shift/signed-SLT decode, memory-wait
// timeout and a one-cycle precise exception state.
module mc_ctrl_ex #(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               reset,
    mc_ctrl_ex_if.master       bus,
    output logic [4:0]         state_out
);
    typedef enum logic [4:0] {
        S_IF     = 5'd0,  S_ID     = 5'd1,  S_MEM_EX = 5'd2,  S_MEM_RD = 5'd3,
        S_LW_WB  = 5'd4,  S_MEM_WD = 5'd5,  S_R_EXE  = 5'd6,  S_R_WB   = 5'd7,
        S_BEQ    = 5'd8,  S_J      = 5'd9,  S_I_EXE  = 5'd10, S_I_WB   = 5'd11,
        S_LUI_WB = 5'd12, S_BNE    = 5'd13, S_JR     = 5'd14, S_JAL    = 5'd15,
        S_EXC    = 5'd16
    } state_t;

    localparam bit WIDE = (ALU_OP_W >= 4);

    localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(3'b000);
    localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(3'b001);
    localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(3'b010);
    localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(3'b011);
    localparam logic [ALU_OP_W-1:0] OP_NOR  = ALU_OP_W'(3'b100);
    localparam logic [ALU_OP_W-1:0] OP_SRLV = ALU_OP_W'(3'b101);
    localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(3'b110);
    localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(3'b111);
    localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(4'b1000);
    localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(4'b1001);
    localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(4'b1010);
    // Narrow ALUs have no signed compare, so signed SLT degrades to SLTU.
    localparam logic [ALU_OP_W-1:0] OP_SLT  = WIDE ? ALU_OP_W'(4'b1011) : OP_SLTU;

    localparam logic [5:0] OPC_R     = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [1:0] C_OVF  = 2'b01;
    localparam logic [1:0] C_BUS  = 2'b10;
    localparam logic [1:0] C_RSVD = 2'b11;

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // The limit fires on the edge closing the MEM_TIMEOUT-th waiting cycle.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t              state;
    state_t              nxt;
    logic [1:0]          cause_q;
    logic [1:0]          nxt_cause;
    logic [CNT_W-1:0]    wait_cnt;
    logic                waiting;
    logic                timeout;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                r_valid;
    logic                r_trap_ovf;
    logic [ALU_OP_W-1:0] r_alu;
    logic [ALU_OP_W-1:0] i_alu;

    assign opcode    = bus.Inst_in[31:26];
    assign funct     = bus.Inst_in[5:0];
    assign state_out = state;
    assign bus.cause = cause_q;

    assign waiting = (state == S_IF || state == S_MEM_RD || state == S_MEM_WD) && !bus.MIO_ready;
    assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == LIMIT);

    always_comb begin
        r_valid    = 1'b1;
        r_trap_ovf = 1'b0;
        r_alu      = OP_ADD;
        case (funct)
            FN_ADD:  begin r_alu = OP_ADD; r_trap_ovf = 1'b1; end
            FN_ADDU: r_alu = OP_ADD;
            FN_SUB:  begin r_alu = OP_SUB; r_trap_ovf = 1'b1; end
            FN_SUBU: r_alu = OP_SUB;
            FN_AND:  r_alu = OP_AND;
            FN_OR:   r_alu = OP_OR;
            FN_XOR:  r_alu = OP_XOR;
            FN_NOR:  r_alu = OP_NOR;
            FN_SRLV: r_alu = OP_SRLV;
            FN_SLTU: r_alu = OP_SLTU;
            FN_SLT:  r_alu = OP_SLT;
            FN_SLL:  begin r_alu = OP_SLL; r_valid = WIDE; end
            FN_SRL:  begin r_alu = OP_SRL; r_valid = WIDE; end
            FN_SRA:  begin r_alu = OP_SRA; r_valid = WIDE; end
            FN_JR:   r_alu = OP_ADD;
            default: r_valid = 1'b0;
        endcase
    end

    always_comb begin
        i_alu = OP_ADD;
        case (opcode)
            OPC_ANDI:  i_alu = OP_AND;
            OPC_ORI:   i_alu = OP_OR;
            OPC_XORI:  i_alu = OP_XOR;
            OPC_SLTI:  i_alu = OP_SLT;
            OPC_SLTIU: i_alu = OP_SLTU;
            default:   i_alu = OP_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IF;
            cause_q  <= 2'b00;
            wait_cnt <= '0;
        end else begin
            state   <= nxt;
            cause_q <= nxt_cause;
            if (nxt != state)
                wait_cnt <= '0;
            else if (waiting && MEM_TIMEOUT != 0)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt               = S_IF;
        nxt_cause         = 2'b00;
        bus.MemRead       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.CPU_MIO       = 1'b0;
        bus.IorD          = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.ALUSrcA       = 1'b0;
        bus.PCWrite       = 1'b0;
        bus.PCWriteCond   = 1'b0;
        bus.Branch        = 1'b0;
        bus.RegDst        = 2'b00;
        bus.MemtoReg      = 2'b00;
        bus.ALUSrcB       = 2'b00;
        bus.PCSource      = 2'b00;
        bus.ALU_operation = OP_ADD;
        bus.EPCWrite      = 1'b0;
        bus.CauseWrite    = 1'b0;
        case (state)
            S_IF: begin
                bus.MemRead = 1'b1;
                bus.CPU_MIO = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.MIO_ready;
                bus.PCWrite = bus.MIO_ready;
                if (bus.MIO_ready) nxt = S_ID;
                else if (timeout) begin nxt = S_EXC; nxt_cause = C_BUS; end
                else nxt = S_IF;
            end
            S_ID: begin
                bus.ALUSrcB = 2'b11;
                case (opcode)
                    OPC_R: begin
                        if (funct == FN_JR) nxt = S_JR;
                        else if (r_valid) nxt = S_R_EXE;
                        else begin nxt = S_EXC; nxt_cause = C_RSVD; end
                    end
                    OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_SLTI, OPC_SLTIU: nxt = S_I_EXE;
                    OPC_LUI:         nxt = S_LUI_WB;
                    OPC_LW, OPC_SW:  nxt = S_MEM_EX;
                    OPC_BEQ:         nxt = S_BEQ;
                    OPC_BNE:         nxt = S_BNE;
                    OPC_J:           nxt = S_J;
                    OPC_JAL:         nxt = S_JAL;
                    default: begin nxt = S_EXC; nxt_cause = C_RSVD; end
                endcase
            end
            S_R_EXE: begin
                bus.ALUSrcA       = 1'b1;
                bus.ALU_operation = r_alu;
                if (r_trap_ovf && bus.overflow) begin nxt = S_EXC; nxt_cause = C_OVF; end
                else nxt = S_R_WB;
            end
            S_R_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 2'b01;
            end
            S_I_EXE: begin
                bus.ALUSrcA       = 1'b1;
                bus.ALUSrcB       = 2'b10;
                bus.ALU_operation = i_alu;
                if (opcode == OPC_ADDI && bus.overflow) begin nxt = S_EXC; nxt_cause = C_OVF; end
                else nxt = S_I_WB;
            end
            S_I_WB:   bus.RegWrite = 1'b1;
            S_LUI_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 2'b10;
            end
            S_MEM_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                nxt = (opcode == OPC_LW) ? S_MEM_RD : S_MEM_WD;
            end
            S_MEM_RD: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
                bus.CPU_MIO = 1'b1;
                if (bus.MIO_ready) nxt = S_LW_WB;
                else if (timeout) begin nxt = S_EXC; nxt_cause = C_BUS; end
                else nxt = S_MEM_RD;
            end
            S_MEM_WD: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                bus.CPU_MIO  = 1'b1;
                if (bus.MIO_ready) nxt = S_IF;
                else if (timeout) begin nxt = S_EXC; nxt_cause = C_BUS; end
                else nxt = S_MEM_WD;
            end
            S_LW_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 2'b01;
            end
            S_BEQ, S_BNE: begin
                bus.ALUSrcA       = 1'b1;
                bus.ALU_operation = OP_SUB;
                bus.PCWriteCond   = 1'b1;
                bus.PCSource      = 2'b01;
                bus.Branch        = (state == S_BEQ);
            end
            S_J: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            S_JAL: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                bus.RegWrite = 1'b1;
                bus.RegDst   = 2'b10;
                bus.MemtoReg = 2'b11;
            end
            S_JR: begin
                bus.ALUSrcA = 1'b1;
                bus.PCWrite = 1'b1;
            end
            S_EXC: begin
                bus.EPCWrite   = 1'b1;
                bus.CauseWrite = 1'b1;
                bus.PCWrite    = 1'b1;
                bus.PCSource   = 2'b11;
            end
            default: nxt = S_IF;
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl_ex.sv
// Directed bench for mc_ctrl_ex: a narrow-ALU/timeout instance and a wide-ALU/no-timeout instance.
module tb_mc_ctrl_ex;
    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] inst = 32'h0;
    logic        zero = 1'b0;
    logic        ovf = 1'b0;
    logic        rdy = 1'b0;
    logic [4:0]  st_a;
    logic [4:0]  st_b;
    logic [4:0]  exp_q[$];
    int          errors = 0;
    int          checks = 0;

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_SW   = 32'hAC220004;
    localparam logic [31:0] I_BNE  = 32'h14220003;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_JAL  = 32'h0C000010;
    localparam logic [31:0] I_JR   = 32'h03E00008;
    localparam logic [31:0] I_LUI  = 32'h3C01FFFF;
    localparam logic [31:0] I_ADDI = 32'h20220005;
    localparam logic [31:0] I_SLTI = 32'h28220005;
    localparam logic [31:0] I_RSVD = 32'h7C000000;
    localparam logic [31:0] I_SLL  = 32'h00011080;
    localparam logic [31:0] I_SLT  = 32'h0022182A;

    always #5 clk = ~clk;

    mc_ctrl_ex_if #(.ALU_OP_W(3)) if_a ();
    mc_ctrl_ex_if #(.ALU_OP_W(4)) if_b ();

    assign if_a.Inst_in = inst;  assign if_b.Inst_in = inst;
    assign if_a.zero = zero;     assign if_b.zero = zero;
    assign if_a.overflow = ovf;  assign if_b.overflow = ovf;
    assign if_a.MIO_ready = rdy; assign if_b.MIO_ready = rdy;

    mc_ctrl_ex #(.ALU_OP_W(3), .MEM_TIMEOUT(4)) u_a (
        .clk(clk), .reset(rst_a), .bus(if_a.master), .state_out(st_a));
    mc_ctrl_ex #(.ALU_OP_W(4), .MEM_TIMEOUT(0)) u_b (
        .clk(clk), .reset(rst_b), .bus(if_b.master), .state_out(st_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference for the few outputs that are pure functions of the state code.
    task automatic expect_state(input logic [4:0] e);
        #1;
        check("state", 32'(st_a), 32'(e));
        check("reg_write", 32'(if_a.RegWrite), 32'(e == 5'd4 || e == 5'd7 || e == 5'd11 || e == 5'd12 || e == 5'd15));
        check("mem_read", 32'(if_a.MemRead), 32'(e == 5'd0 || e == 5'd3));
        check("mem_write", 32'(if_a.MemWrite), 32'(e == 5'd5));
    endtask

    task automatic drain();
        logic [4:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            expect_state(e);
            tick();
        end
    endtask

    task automatic check_exc(input logic [1:0] c);
        expect_state(5'd16);
        check("exc_cause", 32'(if_a.cause), 32'(c));
        check("exc_epc", 32'(if_a.EPCWrite), 32'd1);
        check("exc_causewr", 32'(if_a.CauseWrite), 32'd1);
        check("exc_pcwrite", 32'(if_a.PCWrite), 32'd1);
        check("exc_pcsrc", 32'(if_a.PCSource), 32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        // Reset values and the combinational ready gate in IF.
        rdy = 1'b0;
        tick();
        check("rst_state", 32'(st_a), 32'd0);
        check("rst_memread", 32'(if_a.MemRead), 32'd1);
        check("rst_cpu_mio", 32'(if_a.CPU_MIO), 32'd1);
        check("rst_alusrcb", 32'(if_a.ALUSrcB), 32'd1);
        check("rst_aluop", 32'(if_a.ALU_operation), 32'd2);
        check("rst_cause", 32'(if_a.cause), 32'd0);
        check("rst_irwrite_lo", 32'(if_a.IRWrite), 32'd0);
        rdy = 1'b1;
        #1;
        check("rst_irwrite_hi", 32'(if_a.IRWrite), 32'd1);
        check("rst_pcwrite_hi", 32'(if_a.PCWrite), 32'd1);
        tick();
        check("rst_hold", 32'(st_a), 32'd0);
        rst_a = 1'b1;

        // add: IF, ID, R_EXE, R_WB
        inst = I_ADD;
        exp_q = '{5'd0, 5'd1};
        drain();
        expect_state(5'd6);
        check("add_aluop", 32'(if_a.ALU_operation), 32'd2);
        check("add_alusrca", 32'(if_a.ALUSrcA), 32'd1);
        tick();
        expect_state(5'd7);
        check("add_regdst", 32'(if_a.RegDst), 32'd1);
        tick();

        // add overflowing in R_EXE traps without a register write
        exp_q = '{5'd0, 5'd1};
        drain();
        ovf = 1'b1;
        expect_state(5'd6);
        tick();
        ovf = 1'b0;
        check_exc(2'b01);
        tick();

        // lw with memory stalled four cycles -> bus timeout
        inst = I_LW;
        exp_q = '{5'd0, 5'd1, 5'd2};
        drain();
        rdy = 1'b0;
        exp_q = '{5'd3, 5'd3, 5'd3, 5'd3};
        drain();
        check_exc(2'b10);
        rdy = 1'b1;
        tick();

        // lw with ready arriving in the last allowed cycle completes
        exp_q = '{5'd0, 5'd1, 5'd2};
        drain();
        rdy = 1'b0;
        exp_q = '{5'd3, 5'd3, 5'd3};
        drain();
        rdy = 1'b1;
        expect_state(5'd3);
        check("lw_iord", 32'(if_a.IorD), 32'd1);
        tick();
        expect_state(5'd4);
        check("lw_memtoreg", 32'(if_a.MemtoReg), 32'd1);
        check("lw_cause", 32'(if_a.cause), 32'd0);
        tick();

        // sw zero-wait: 4 cycles
        inst = I_SW;
        exp_q = '{5'd0, 5'd1, 5'd2, 5'd5};
        drain();

        // bne and beq
        inst = I_BNE;
        exp_q = '{5'd0, 5'd1};
        drain();
        expect_state(5'd13);
        check("bne_pcwc", 32'(if_a.PCWriteCond), 32'd1);
        check("bne_branch", 32'(if_a.Branch), 32'd0);
        check("bne_pcsrc", 32'(if_a.PCSource), 32'd1);
        check("bne_aluop", 32'(if_a.ALU_operation), 32'd6);
        tick();
        inst = I_BEQ;
        exp_q = '{5'd0, 5'd1};
        drain();
        expect_state(5'd8);
        check("beq_branch", 32'(if_a.Branch), 32'd1);
        tick();

        // jal, jr, lui
        inst = I_JAL;
        exp_q = '{5'd0, 5'd1};
        drain();
        expect_state(5'd15);
        check("jal_regdst", 32'(if_a.RegDst), 32'd2);
        check("jal_memtoreg", 32'(if_a.MemtoReg), 32'd3);
        check("jal_pcsrc", 32'(if_a.PCSource), 32'd2);
        check("jal_pcwrite", 32'(if_a.PCWrite), 32'd1);
        tick();
        inst = I_JR;
        exp_q = '{5'd0, 5'd1};
        drain();
        expect_state(5'd14);
        check("jr_pcwrite", 32'(if_a.PCWrite), 32'd1);
        check("jr_pcsrc", 32'(if_a.PCSource), 32'd0);
        check("jr_alusrca", 32'(if_a.ALUSrcA), 32'd1);
        tick();
        inst = I_LUI;
        exp_q = '{5'd0, 5'd1};
        drain();
        expect_state(5'd12);
        check("lui_memtoreg", 32'(if_a.MemtoReg), 32'd2);
        tick();

        // addi overflow traps; slti on the narrow ALU uses SLTU
        inst = I_ADDI;
        exp_q = '{5'd0, 5'd1};
        drain();
        ovf = 1'b1;
        expect_state(5'd10);
        check("addi_alusrcb", 32'(if_a.ALUSrcB), 32'd2);
        tick();
        ovf = 1'b0;
        check_exc(2'b01);
        tick();
        inst = I_SLTI;
        exp_q = '{5'd0, 5'd1};
        drain();
        expect_state(5'd10);
        check("slti_aluop_narrow", 32'(if_a.ALU_operation), 32'd7);
        tick();
        exp_q = '{5'd11};
        drain();

        // reserved opcode and sll on the narrow ALU are reserved instructions
        inst = I_RSVD;
        exp_q = '{5'd0, 5'd1};
        drain();
        check_exc(2'b11);
        tick();
        inst = I_SLL;
        exp_q = '{5'd0, 5'd1};
        drain();
        check_exc(2'b11);
        tick();

        // fetch timeout in IF
        rdy = 1'b0;
        exp_q = '{5'd0, 5'd0, 5'd0, 5'd0};
        drain();
        check_exc(2'b10);
        rdy = 1'b1;
        tick();

        // reset during MEM_WD aborts the store immediately
        inst = I_SW;
        exp_q = '{5'd0, 5'd1, 5'd2};
        drain();
        rdy = 1'b0;
        expect_state(5'd5);
        rst_a = 1'b0;
        #1;
        check("abort_state", 32'(st_a), 32'd0);
        check("abort_memwrite", 32'(if_a.MemWrite), 32'd0);
        check("abort_irwrite_lo", 32'(if_a.IRWrite), 32'd0);
        rdy = 1'b1;
        #1;
        check("abort_irwrite_hi", 32'(if_a.IRWrite), 32'd1);
        tick();
        rst_a = 1'b1;
        exp_q = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd0};
        drain();

        // wide ALU instance: shifts and signed SLT decode, no timeout
        rst_a = 1'b0;
        rst_b = 1'b1;
        inst = I_SLL;
        check("b_state0", 32'(st_b), 32'd0);
        tick();
        check("b_state1", 32'(st_b), 32'd1);
        tick();
        check("b_sll_state", 32'(st_b), 32'd6);
        check("b_sll_aluop", 32'(if_b.ALU_operation), 32'h8);
        tick();
        check("b_sll_wb", 32'(st_b), 32'd7);
        check("b_sll_regwrite", 32'(if_b.RegWrite), 32'd1);
        tick();
        inst = I_SLT;
        tick();
        tick();
        check("b_slt_state", 32'(st_b), 32'd6);
        check("b_slt_aluop", 32'(if_b.ALU_operation), 32'hB);
        tick();
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("b_no_timeout", 32'(st_b), 32'd0);
        check("b_no_exc", 32'(if_b.CauseWrite), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_ex.md
# mc_ctrl_ex

Parametrised multi-cycle MIPS control unit, successor to the fixed-function controller. Sits between the instruction register/ALU flags and the shared-memory multi-cycle datapath, driving all datapath enables, muxes and the ALU opcode. Adds three things to the base instruction set: a configurable ALU opcode width for shifts and signed SLT, a memory-wait timeout, and a precise exception state for overflow, bus timeout and reserved instructions.

## Interface
- ALU_OP_W, 3: ALU opcode width, 3 or 4. At 4, SLL/SRL/SRA/SLT(signed) are decoded; at 3 those shifts are reserved instructions and SLT maps to SLTU.
- MEM_TIMEOUT, 0: maximum number of cycles waiting on MIO_ready before a bus-error exception; 0 disables the timeout.
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; low forces state IF
- Inst_in  in  32  instruction register contents
- zero, overflow  in  1  ALU flags, valid in the ALU's execute cycle
- MIO_ready  in  1  memory handshake
- MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch  out  1  datapath controls (meanings unchanged)
- RegDst, MemtoReg, ALUSrcB  out  2  mux selects (encodings unchanged)
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector
- ALU_operation  out  ALU_OP_W  ADD 010, SUB 110, AND 000, OR 001, XOR 011, NOR 100, SRLV 101, SLTU 111. When ALU_OP_W=4, MSB=0 for these; SLL 1000, SRL 1001, SRA 1010, SLT 1011.
- EPCWrite, CauseWrite  out  1  capture PC into EPC and cause into CAUSE
- cause  out  2  01 overflow, 10 bus timeout, 11 reserved instruction, 00 none
- state_out  out  5  current state code

## Operation
- State register is 5 bits. State codes: IF 0, ID 1, MEM_EX 2, MEM_RD 3, LW_WB 4, MEM_WD 5, R_EXE 6, R_WB 7, BEQ 8, J 9, I_EXE 10, I_WB 11, LUI_WB 12, BNE 13, JR 14, JAL 15, EXC 16. Codes 17–31 go to IF on the next edge.
- Outputs are combinational decodes of state, Inst_in and the latched cause. Every output not listed for a state is 0.
- IF: MemRead=1, CPU_MIO=1, ALUSrcB=01, ALU ADD. IRWrite=PCWrite=MIO_ready (combinational gate). Go to ID when MIO_ready=1.
- ID: ALUSrcB=11, ALU ADD (branch target). Dispatch on opcode/funct:
  - R-type → R_EXE; funct 001000 → JR.
  - ADDI/ANDI/ORI/XORI/SLTI/SLTIU → I_EXE.
  - LUI → LUI_WB; LW/SW → MEM_EX; BEQ → BEQ; BNE → BNE; J → J; JAL → JAL.
  - Any other opcode, or an undecodable funct → EXC with cause 11.
- R_EXE: ALUSrcA=1, ALUSrcB=00, ALU op from funct. If funct is ADD or SUB and overflow=1 → EXC with cause 01; otherwise → R_WB.
- R_WB: RegWrite=1, RegDst=01, MemtoReg=00 → IF.
- I_EXE: ALUSrcA=1, ALUSrcB=10, ALU op from opcode. ADDI with overflow=1 → EXC with cause 01; otherwise → I_WB.
- I_WB: RegWrite=1, RegDst=00 → IF.
- LUI_WB: RegWrite=1, MemtoReg=10 → IF.
- MEM_EX: ALUSrcA=1, ALUSrcB=10, ADD → MEM_RD (LW) or MEM_WD (SW).
- MEM_RD: IorD=1, MemRead=1, CPU_MIO=1; on MIO_ready → LW_WB.
- MEM_WD: IorD=1, MemWrite=1, CPU_MIO=1; on MIO_ready → IF.
- LW_WB: RegWrite=1, MemtoReg=01 → IF.
- BEQ/BNE: ALUSrcA=1, SUB, PCWriteCond=1, PCSource=01, Branch=1 (BEQ) or 0 (BNE) → IF.
- J: PCWrite=1, PCSource=10 → IF.
- JAL: as J, plus RegWrite=1, RegDst=10, MemtoReg=11 → IF.
- JR: ALUSrcA=1, PCWrite=1, PCSource=00, ALU ADD with ALUSrcB=00 (rs+0) → IF.
- EXC (one cycle): EPCWrite=1, CauseWrite=1, PCWrite=1, PCSource=11 → IF.
- Wait counter: clog2(MEM_TIMEOUT+1) bits. Clears on any state change; counts while in IF/MEM_RD/MEM_WD with MIO_ready=0. When MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with MIO_ready still 0 → EXC with cause 10; MemRead/MemWrite drop on entering EXC.

## Timing
- While reset is low: state=IF, counter=0, latched cause=00. Outputs take the IF values: MemRead=1, CPU_MIO=1, ALUSrcB=01, ALU_operation=ADD, IRWrite=PCWrite=MIO_ready.
- Cycle counts with zero-wait memory:
  - R-type: 4; I-type: 4.
  - LW: 5; SW: 4.
  - Branch/J/JAL/JR/LUI: 3.
  - Trapped instruction: 4 (IF, ID, EXE, EXC), with no RegWrite.
- MIO_ready arriving on the same edge as the timeout limit is treated as ready; no exception.
- A reset assertion mid-instruction aborts it immediately. No partial register write occurs after reset deasserts.

## Test plan
- add $3,$1,$2 with ready held high → states 0,1,6,7,0; RegWrite=1 only in state 7; ALU_operation=010.
- add with overflow=1 in R_EXE → next state 16; cause=01; EPCWrite=PCWrite=1, PCSource=11; RegWrite never asserted.
- MEM_TIMEOUT=4, LW with MIO_ready low in MEM_RD → after 4 wait cycles state=16, cause=10; with ready on cycle 4 → LW_WB.
- ALU_OP_W=4: sll → ALU_operation=1000; ALU_OP_W=3: sll → EXC with cause 11.
- bne with zero=0 → PCWriteCond=1, Branch=0, PCSource=01 in state 13; jal → RegDst=10, MemtoReg=11, PCSource=10.
- reset driven low during MEM_WD → MemWrite=0 and state_out=0 immediately; after release, IF with IRWrite tracking MIO_ready.
